// File: rtl/register_file_dumper_if.sv
// Bus bundle between the register file dumper, the register file read port
// and the debug TX byte stream.
interface register_file_dumper_if #(
    parameter int unsigned NB_ADDR = 5,
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_BYTE = 8
) ();
    logic               i_start;
    logic [NB_ADDR-1:0] o_read_addr;
    logic [NB_DATA-1:0] i_read_data;
    logic [NB_BYTE-1:0] o_tx_data;
    logic               o_tx_valid;
    logic               i_tx_ready;
    logic               o_busy;
    logic               o_done;

    // Dumper side: drives the read address and the byte stream.
    modport master (
        input  i_start,
        output o_read_addr,
        input  i_read_data,
        output o_tx_data,
        output o_tx_valid,
        input  i_tx_ready,
        output o_busy,
        output o_done
    );

    // Environment side: debug unit, register file and TX path.
    modport slave (
        output i_start,
        input  o_read_addr,
        output i_read_data,
        input  o_tx_data,
        input  o_tx_valid,
        output i_tx_ready,
        input  o_busy,
        input  o_done
    );
endinterface

// File: rtl/register_file_dumper.sv
// Walks every register file address, snapshots each word and streams it out
// MSB byte first over a valid/ready byte interface.
module register_file_dumper #(
    parameter int unsigned NB_ADDR = 5,
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned N_REGS  = 2 ** NB_ADDR,
    parameter int unsigned NB_BYTE = 8
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    register_file_dumper_if.master  io_bus
);
    localparam int unsigned N_BYTES = NB_DATA / NB_BYTE;
    localparam int unsigned NB_CNT  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    typedef enum logic [2:0] {StIdle, StLoad, StSend, StNext, StDone} state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [NB_ADDR-1:0] r_reg_idx;
    logic [NB_CNT-1:0]  r_byte_cnt;
    logic [NB_DATA-1:0] r_shift;

    logic w_handshake;
    logic w_last_byte;
    logic w_last_reg;

    // Valid is decoded from state, so the handshake only needs ready in SEND.
    assign w_handshake = (r_state == StSend) && io_bus.i_tx_ready;
    assign w_last_byte = (r_byte_cnt == NB_CNT'(N_BYTES - 1));
    assign w_last_reg  = (r_reg_idx == NB_ADDR'(N_REGS - 1));

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: if (io_bus.i_start) w_state_next = StLoad;
            StLoad: w_state_next = StSend;
            StSend: if (w_handshake && w_last_byte) w_state_next = StNext;
            StNext: w_state_next = w_last_reg ? StDone : StLoad;
            StDone: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Datapath: register index, byte counter and the word snapshot.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_reg_idx  <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (io_bus.i_start) r_reg_idx <= '0;
                end
                StLoad: begin
                    // The word is captured only here; later writes cannot touch it.
                    r_shift    <= io_bus.i_read_data;
                    r_byte_cnt <= '0;
                end
                StSend: begin
                    if (w_handshake && !w_last_byte) begin
                        r_shift    <= r_shift << NB_BYTE;
                        r_byte_cnt <= r_byte_cnt + NB_CNT'(1);
                    end
                end
                StNext: begin
                    if (!w_last_reg) r_reg_idx <= r_reg_idx + NB_ADDR'(1);
                end
                StDone: begin
                    r_reg_idx <= '0;
                end
                default: ;
            endcase
        end
    end

    // Outputs, all decoded from registered state.
    always_comb begin
        io_bus.o_read_addr = r_reg_idx;
        io_bus.o_tx_valid  = (r_state == StSend);
        io_bus.o_tx_data   = r_shift[NB_DATA-1 -: NB_BYTE];
        io_bus.o_busy      = (r_state != StIdle);
        io_bus.o_done      = (r_state == StDone);
    end
endmodule
